clm_subbytes_drv: RTL and testbench
===================================

CLM_SUBBYTES_DRV -- requirements
Module: clm_subbytes_drv

Interface
REQ-001 Parameter: d, default d from package types, masking order; state_t width is m+d with m=8.
REQ-002 Parameter: N_LANES, default 16, number of state bytes sequenced per operation.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port start_i  in  1  request to process state_i; one-cycle pulse.
REQ-006 Port state_i  in  N_LANES x state_t  masked input bytes; sampled on start acceptance.
REQ-007 Port rnd_i  in  7 x state_t  fresh randomness; sampled at each byte issue.
REQ-008 Port busy_o  out  1  high from start acceptance until done or error.
REQ-009 Port done_o  out  1  one-cycle pulse; state_o valid from this cycle.
REQ-010 Port state_o  out  N_LANES x state_t  substituted bytes; held until next start acceptance.
REQ-011 Port sbox_in_o  out  state_t  drives S-box in.
REQ-012 Port sbox_r_o  out  7 x state_t  drives S-box r[0..6].
REQ-013 Port sbox_drdy_i_o  out  1  drives S-box drdy_i (issue strobe).
REQ-014 Port sbox_drdy_o_i  in  1  S-box drdy_o; S-box out valid when high.
REQ-015 Port sbox_out_i  in  state_t  S-box out.
REQ-016 Port err_o  out  1  watchdog error, sticky.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE, ERR (ERR reachable only with watchdog compiled in).
REQ-018 IDLE: start_i=1 -> copy state_i into lane buffer, lane counter=0, -> ISSUE; start_i=0 -> stay.
REQ-019 ISSUE: sbox_drdy_i_o=1 exactly this cycle; register rnd_i into r-hold and buffer[lane] into in-hold; -> WAIT.
REQ-020 sbox_in_o and sbox_r_o shall equal in-hold/r-hold and stay constant from ISSUE through the cycle sbox_drdy_o_i is seen.
REQ-021 WAIT: sbox_drdy_i_o=0; on sbox_drdy_o_i=1 write sbox_out_i into buffer[lane]; lane=N_LANES-1 -> DONE, else lane+1 -> ISSUE.
REQ-022 DONE: done_o=1, busy_o=0, one cycle; start_i=1 -> accept as in IDLE, -> ISSUE; else -> IDLE.
REQ-023 Per byte: ISSUE 1 cycle + WAIT 6 cycles = 7 cycles; start accepted cycle 0 -> done_o at cycle 7*N_LANES+1 (113 for 16).
REQ-024 start_i while busy_o=1 shall be ignored, no effect on buffer or counters.
REQ-025 sbox_drdy_o_i outside WAIT shall be ignored.
REQ-026 state_o shall be the lane buffer; lanes not yet processed hold input values during operation.
REQ-027 Lane counter width clog2(N_LANES); no wrap beyond N_LANES-1.

Reset
REQ-028 rst_n=0 shall immediately force IDLE, lane counter 0, buffer/holds 0, busy_o=0, done_o=0, err_o=0, sbox_drdy_i_o=0, sbox_in_o=0, sbox_r_o=0.
REQ-029 Reset mid-operation shall abandon the operation; no done_o follows release.
REQ-030 Driver and S-box shall share reset at integration so both restart aligned.

Configuration
REQ-031 Macro CLM_SUBBYTES_DRV_WATCHDOG_EN defined: 4-bit WAIT counter cleared on ISSUE; reaching 8 WAIT cycles without sbox_drdy_o_i -> ERR; ERR: err_o=1, busy_o=0, sbox_drdy_i_o=0; start_i in ERR clears err_o and is accepted as in IDLE.
REQ-032 Macro undefined: no counter, no ERR state, err_o tied 0, WAIT holds indefinitely.

Structure
REQ-033 Package types shall hold N_LANES default, SBOX_RAND_N=7, and enum drv_state_t; state_t reused from package.
REQ-034 One sub-module clm_lane_buf: N_LANES x state_t buffer with bulk load and single-lane write port, async active-low reset.
REQ-035 S-box instantiated outside this block; only port-level connection.

Verification
REQ-036 Reset, start with state_i lanes = 0x00..0x0F (d=0 unmasked), real S-box -> done_o at cycle 113, state_o lanes = AES S-box(0x00..0x0F) (0x63,0x7C,0x77,...).
REQ-037 Monitor: sbox_drdy_i_o high exactly 16 single cycles per operation, spaced 7 cycles; sbox_in_o/sbox_r_o stable across each byte window.
REQ-038 start_i pulsed at cycles 10 and 50 after acceptance -> ignored, single done_o at 113, result unchanged.
REQ-039 start_i asserted in DONE cycle with new data -> ISSUE next cycle, second done_o exactly 113 cycles after that start.
REQ-040 rst_n low at cycle 40 -> all outputs 0 same cycle; no done_o within 200 cycles after release without new start.
REQ-041 Watchdog on: stub S-box never raises drdy_o -> err_o=1 9 cycles after first ISSUE; next start_i clears err_o; watchdog off: busy_o stays 1.

Source files
------------

// File: rtl/clm_subbytes_drv_pkg.sv
// Shared types for the SubBytes driver: byte/share layout, default lane count and FSM encoding.
// Consumers: clm_subbytes_drv, clm_lane_buf, and any integration wrapper pairing the driver with the S-box.
package types;

   localparam int M               = 8;
   localparam int D               = 0;
   localparam int N_LANES_DEFAULT = 16;
   localparam int SBOX_RAND_N     = 7;

   typedef logic [M+D-1:0] state_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } drv_state_t;

endpackage

// File: rtl/clm_subbytes_drv_lane_buf.sv
// Lane buffer for the SubBytes driver: whole-state bulk load plus one single-lane write port.
// Bulk load wins over the lane write; both are only ever requested in different FSM states.
module clm_lane_buf
   import types::*;
#(
   parameter int N_LANES = N_LANES_DEFAULT,
   parameter int W       = M + D,
   parameter int IW      = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [N_LANES-1:0][W-1:0] load_data,
   input  logic                      wr_en,
   input  logic [IW-1:0]             wr_idx,
   input  logic [W-1:0]              wr_data,
   output logic [N_LANES-1:0][W-1:0] data
);

   logic [W-1:0] lane_reg [N_LANES];

   for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lane_reg[gi] <= '0;
         end else if (load) begin
            lane_reg[gi] <= load_data[gi];
         end else if (wr_en && (wr_idx == IW'(gi))) begin
            lane_reg[gi] <= wr_data;
         end
      end

      assign data[gi] = lane_reg[gi];
   end

endmodule

// File: rtl/clm_subbytes_drv.sv
// Sequences N_LANES masked bytes one at a time through an external multi-cycle S-box.
// Optional WAIT watchdog with sticky err_o: define CLM_SUBBYTES_DRV_WATCHDOG_EN.
module clm_subbytes_drv
   import types::*;
#(
   parameter int d       = D,
   parameter int N_LANES = N_LANES_DEFAULT
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start_i,
   input  logic [N_LANES-1:0][M+d-1:0]         state_i,
   input  logic [SBOX_RAND_N-1:0][M+d-1:0]     rnd_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic [N_LANES-1:0][M+d-1:0]         state_o,
   output logic [M+d-1:0]                      sbox_in_o,
   output logic [SBOX_RAND_N-1:0][M+d-1:0]     sbox_r_o,
   output logic                                sbox_drdy_i_o,
   input  logic                                sbox_drdy_o_i,
   input  logic [M+d-1:0]                      sbox_out_i,
   output logic                                err_o
);

   localparam int            W         = M + d;
   localparam int            IW        = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam logic [IW-1:0] LAST_LANE = IW'(N_LANES - 1);

   drv_state_t                     state_reg, state_next;
   logic [IW-1:0]                  lane_reg, lane_next;
   logic [W-1:0]                   in_hold_reg, in_hold_next;
   logic [SBOX_RAND_N-1:0][W-1:0]  r_hold_reg, r_hold_next;
   logic                           buf_load;
   logic                           buf_wr;
   logic [N_LANES-1:0][W-1:0]      buf_data;
   logic                           wd_expired;

   clm_lane_buf #(
      .N_LANES (N_LANES),
      .W       (W),
      .IW      (IW)
   ) u_lane_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (buf_load),
      .load_data (state_i),
      .wr_en     (buf_wr),
      .wr_idx    (lane_reg),
      .wr_data   (sbox_out_i),
      .data      (buf_data)
   );

`ifdef CLM_SUBBYTES_DRV_WATCHDOG_EN
   logic [3:0] wd_cnt_reg, wd_cnt_next;

   always_comb begin
      wd_cnt_next = wd_cnt_reg;
      if (state_reg == ISSUE) begin
         wd_cnt_next = '0;
      end else if ((state_reg == WAIT) && !sbox_drdy_o_i) begin
         wd_cnt_next = wd_cnt_reg + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_reg <= '0;
      end else begin
         wd_cnt_reg <= wd_cnt_next;
      end
   end

   // Counter value 7 marks the eighth consecutive WAIT cycle without a result.
   assign wd_expired = (state_reg == WAIT) && !sbox_drdy_o_i && (wd_cnt_reg == 4'd7);
   assign err_o      = (state_reg == ERR);
`else
   assign wd_expired = 1'b0;
   assign err_o      = 1'b0;
`endif

   // Holds are loaded on entry to ISSUE so the S-box sees settled operands during the strobe.
   always_comb begin
      state_next   = state_reg;
      lane_next    = lane_reg;
      in_hold_next = in_hold_reg;
      r_hold_next  = r_hold_reg;
      buf_load     = 1'b0;
      buf_wr       = 1'b0;

      case (state_reg)
         IDLE, ERR: begin
            if (start_i) begin
               buf_load = 1'b1;
            end
         end
         DONE: begin
            if (start_i) begin
               buf_load = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         ISSUE: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (sbox_drdy_o_i) begin
               buf_wr = 1'b1;
               if (lane_reg == LAST_LANE) begin
                  state_next = DONE;
               end else begin
                  lane_next    = lane_reg + 1'b1;
                  in_hold_next = buf_data[lane_reg + 1'b1];
                  r_hold_next  = rnd_i;
                  state_next   = ISSUE;
               end
            end else if (wd_expired) begin
               state_next = ERR;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (buf_load) begin
         state_next   = ISSUE;
         lane_next    = '0;
         in_hold_next = state_i[0];
         r_hold_next  = rnd_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         lane_reg    <= '0;
         in_hold_reg <= '0;
         r_hold_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         lane_reg    <= lane_next;
         in_hold_reg <= in_hold_next;
         r_hold_reg  <= r_hold_next;
      end
   end

   assign busy_o        = (state_reg == ISSUE) || (state_reg == WAIT);
   assign done_o        = (state_reg == DONE);
   assign sbox_drdy_i_o = (state_reg == ISSUE);
   assign sbox_in_o     = in_hold_reg;
   assign sbox_r_o      = r_hold_reg;
   assign state_o       = buf_data;

endmodule

// File: tb/tb_clm_subbytes_drv.sv
// Scoreboard bench for clm_subbytes_drv with a 6-cycle behavioural AES S-box model.
// Watchdog checks follow CLM_SUBBYTES_DRV_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_clm_subbytes_drv;
   import types::*;

   localparam int NL  = 16;
   localparam int W   = 8;
   localparam int LAT = 7 * NL + 1;

   typedef logic [NL-1:0][W-1:0] lanes_t;
   typedef struct {
      lanes_t data;
      int     start_cyc;
   } exp_t;

   localparam lanes_t AES_REF = {8'h76, 8'hab, 8'hd7, 8'hfe, 8'h2b, 8'h67, 8'h01, 8'h30,
                                 8'hc5, 8'h6f, 8'h6b, 8'hf2, 8'h7b, 8'h77, 8'h7c, 8'h63};

   logic                          clk = 1'b0;
   logic                          rst_n = 1'b0;
   logic                          start_i = 1'b0;
   lanes_t                        state_i = '0;
   logic [SBOX_RAND_N-1:0][W-1:0] rnd_i = '0;
   logic                          busy_o, done_o, err_o;
   lanes_t                        state_o;
   logic [W-1:0]                  sbox_in_o, sbox_out_i;
   logic [SBOX_RAND_N-1:0][W-1:0] sbox_r_o;
   logic                          sbox_drdy_i_o, sbox_drdy_o_i;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   logic sbox_on = 1'b1;
   logic spur = 1'b0;
   logic [5:0]   sb_v;
   logic [W-1:0] sb_res;
   exp_t sb_q[$];

   clm_subbytes_drv #(
      .d       (0),
      .N_LANES (NL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .state_i       (state_i),
      .rnd_i         (rnd_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .state_o       (state_o),
      .sbox_in_o     (sbox_in_o),
      .sbox_r_o      (sbox_r_o),
      .sbox_drdy_i_o (sbox_drdy_i_o),
      .sbox_drdy_o_i (sbox_drdy_o_i),
      .sbox_out_i    (sbox_out_i),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = '0;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] b;
      b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic lanes_t exp_of(input lanes_t v);
      lanes_t r;
      for (int i = 0; i < NL; i++) r[i] = aes_sbox(v[i]);
      return r;
   endfunction

   function automatic lanes_t rand_lanes();
      lanes_t v;
      for (int i = 0; i < NL; i++) v[i] = W'($urandom_range(0, 255));
      return v;
   endfunction

   // Behavioural S-box: result valid 6 cycles after the issue strobe, shares the driver reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_v   <= '0;
         sb_res <= '0;
      end else begin
         sb_v <= {sb_v[4:0], sbox_drdy_i_o};
         if (sbox_drdy_i_o) sb_res <= aes_sbox(sbox_in_o);
      end
   end

   assign sbox_drdy_o_i = (sbox_on & sb_v[5]) | spur;
   assign sbox_out_i    = spur ? 8'hA5 : sb_res;

   // Monitor: issue spacing, operand stability, and scoreboard compare on done_o.
   int                            issue_cnt = 0;
   int                            last_issue = 0;
   logic                          in_win = 1'b0;
   logic [W-1:0]                  win_in;
   logic [SBOX_RAND_N-1:0][W-1:0] win_r;
   exp_t                          mon_e;

   always @(negedge clk) begin
      if (!rst_n || err_o) begin
         issue_cnt = 0;
         in_win    = 1'b0;
      end else begin
         if (in_win) begin
            check_eq("sbox_in_stable", 256'(sbox_in_o), 256'(win_in));
            check_eq("sbox_r_stable", 256'(sbox_r_o), 256'(win_r));
            if (sbox_drdy_o_i) in_win = 1'b0;
         end
         if (sbox_drdy_i_o) begin
            if (issue_cnt > 0) check_eq("issue_spacing", 256'(cyc - last_issue), 256'(7));
            issue_cnt++;
            last_issue = cyc;
            in_win     = 1'b1;
            win_in     = sbox_in_o;
            win_r      = sbox_r_o;
         end
         if (done_o) begin
            if (sb_q.size() == 0) begin
               check_eq("unexpected_done", 256'(done_o), 256'(0));
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("result", 256'(state_o), 256'(mon_e.data));
               check_eq("done_latency", 256'(cyc - mon_e.start_cyc), 256'(LAT));
               check_eq("issue_count", 256'(issue_cnt), 256'(NL));
               $display("op done: cycle %0d latency %0d issues %0d state_o %h",
                        cyc, cyc - mon_e.start_cyc, issue_cnt, state_o);
            end
            issue_cnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < SBOX_RAND_N; i++) rnd_i[i] = W'($urandom_range(0, 255));
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done_o && n < budget) begin
         tick();
         n++;
      end
      check_eq("done_seen", 256'(done_o), 256'(1));
   endtask

   task automatic start_op(input lanes_t data, input lanes_t exp, input bit push, output int t0);
      exp_t e;
      state_i = data;
      start_i = 1'b1;
      t0      = cyc;
      if (push) begin
         e.data      = exp;
         e.start_cyc = cyc;
         sb_q.push_back(e);
      end
      tick();
      start_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 256'(busy_o), 256'(0));
      check_eq({tag, "_done"}, 256'(done_o), 256'(0));
      check_eq({tag, "_err"}, 256'(err_o), 256'(0));
      check_eq({tag, "_drdy_i"}, 256'(sbox_drdy_i_o), 256'(0));
      check_eq({tag, "_sbox_in"}, 256'(sbox_in_o), 256'(0));
      check_eq({tag, "_sbox_r"}, 256'(sbox_r_o), 256'(0));
      check_eq({tag, "_state_o"}, 256'(state_o), 256'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      lanes_t d_a, d_b, d_c, d_d, d_e;
      int     t0, t1, nd;

      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Operation A: lanes 0x00..0x0F with ignored starts at +10 and +50.
      for (int i = 0; i < NL; i++) d_a[i] = W'(i);
      start_op(d_a, AES_REF, 1'b1, t0);
      wait_until(t0 + 10);
      check_eq("lane0_mid", 256'(state_o[0]), 256'(8'h63));
      check_eq("lane15_mid", 256'(state_o[NL-1]), 256'(8'h0f));
      state_i = rand_lanes();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_until(t0 + 50);
      state_i = rand_lanes();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done(200);

      // Operation B: started in the DONE cycle of A.
      d_b = rand_lanes();
      start_op(d_b, exp_of(d_b), 1'b1, t1);
      check_eq("issue_after_done", 256'(sbox_drdy_i_o), 256'(1));
      check_eq("first_in_b", 256'(sbox_in_o), 256'(d_b[0]));
      wait_done(200);

      // Stray S-box valid while idle must not touch the buffer.
      repeat (3) tick();
      spur = 1'b1;
      tick();
      spur = 1'b0;
      check_eq("ignore_drdy_idle", 256'(state_o), 256'(exp_of(d_b)));
      check_eq("idle_busy", 256'(busy_o), 256'(0));

      // Operation C: aborted by reset at +40.
      d_c = rand_lanes();
      start_op(d_c, '0, 1'b0, t0);
      wait_until(t0 + 40);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      tick();
      tick();
      rst_n = 1'b1;
      nd = 0;
      repeat (200) begin
         tick();
         if (done_o) nd++;
      end
      check_eq("no_done_after_rst", 256'(nd), 256'(0));

      // Operation D: S-box never answers.
      sbox_on = 1'b0;
      d_d = rand_lanes();
      start_op(d_d, '0, 1'b0, t0);
`ifdef CLM_SUBBYTES_DRV_WATCHDOG_EN
      wait_until(t0 + 9);
      check_eq("wd_err_early", 256'(err_o), 256'(0));
      check_eq("wd_busy_early", 256'(busy_o), 256'(1));
      tick();
      check_eq("wd_err_set", 256'(err_o), 256'(1));
      check_eq("wd_busy_clr", 256'(busy_o), 256'(0));
      check_eq("wd_drdy_i", 256'(sbox_drdy_i_o), 256'(0));
      tick();
      check_eq("wd_err_sticky", 256'(err_o), 256'(1));
      sbox_on = 1'b1;
      d_e = rand_lanes();
      start_op(d_e, exp_of(d_e), 1'b1, t1);
      check_eq("wd_err_cleared", 256'(err_o), 256'(0));
      wait_done(200);
`else
      wait_until(t0 + 150);
      check_eq("hang_busy", 256'(busy_o), 256'(1));
      check_eq("hang_done", 256'(done_o), 256'(0));
      check_eq("hang_err", 256'(err_o), 256'(0));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sbox_on = 1'b1;
      d_e = rand_lanes();
      start_op(d_e, exp_of(d_e), 1'b1, t1);
      wait_done(200);
`endif

      repeat (3) tick();
      check_eq("queue_empty", 256'(sb_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
